ysyx_24100006_xbar_rd: RTL and testbench

YSYX_24100006_XBAR_RD -- requirements
Module: ysyx_24100006_xbar_rd

---
 rtl/ysyx_24100006_xbar_rd.sv | 134 +++++++++++++
 tb/tb_ysyx_24100006_xbar_rd.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_xbar_rd.sv
// Read-channel crossbar: one upstream load/store master fanned out to the CLINT timer
// slave or the memory/SoC slave, decoded from the latched request address.
module ysyx_24100006_xbar_rd #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rlast,
    output logic        m_rvalid,
    input  logic        m_rready,

    output logic [31:0] c_araddr,
    output logic        c_arvalid,
    input  logic        c_arready,
    input  logic [31:0] c_rdata,
    input  logic [1:0]  c_rresp,
    input  logic        c_rlast,
    input  logic        c_rvalid,
    output logic        c_rready,

    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic        s_rvalid,
    output logic        s_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        sel_q, sel_d;   // 1: CLINT slave, 0: memory slave

    logic        clint_hit;
    logic        sel_arready;
    logic        sel_rvalid;

    assign clint_hit   = (m_araddr & CLINT_MASK) == (CLINT_BASE & CLINT_MASK);
    assign sel_arready = sel_q ? c_arready : s_arready;
    assign sel_rvalid  = sel_q ? c_rvalid  : s_rvalid;

    // Both slaves see the latched address permanently; only arvalid is steered.
    assign c_araddr = addr_q;
    assign s_araddr = addr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
        end
    end

    // NOTE: every comb output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (m_arvalid) begin
                    addr_d  = m_araddr;
                    sel_d   = clint_hit;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (sel_arready) state_d = DATA;
            end
            DATA: begin
                if (sel_rvalid && m_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'h0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        c_arvalid = 1'b0;
        s_arvalid = 1'b0;
        c_rready  = 1'b0;
        s_rready  = 1'b0;
        unique case (state_q)
            IDLE: m_arready = 1'b1;
            ADDR: begin
                c_arvalid = sel_q;
                s_arvalid = !sel_q;
            end
            DATA: begin
                // Response is a pure combinational pass-through of the selected slave.
                if (sel_q) begin
                    c_rready = m_rready;
                    m_rvalid = c_rvalid;
                    m_rdata  = c_rdata;
                    m_rresp  = c_rresp;
                    m_rlast  = c_rlast;
                end else begin
                    s_rready = m_rready;
                    m_rvalid = s_rvalid;
                    m_rdata  = s_rdata;
                    m_rresp  = s_rresp;
                    m_rlast  = s_rlast;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100006_xbar_rd.sv
// Directed bench for the read crossbar: decode, latency, back-pressure, reset abort,
// error-response pass-through.
module tb_ysyx_24100006_xbar_rd;

    logic        clk;
    logic        reset;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] c_araddr;
    logic        c_arvalid;
    logic        c_arready;
    logic [31:0] c_rdata;
    logic [1:0]  c_rresp;
    logic        c_rlast;
    logic        c_rvalid;
    logic        c_rready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;

    int n_total = 0;
    int n_pass  = 0;

    ysyx_24100006_xbar_rd dut (
        .clk       (clk),
        .reset     (reset),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .c_araddr  (c_araddr),
        .c_arvalid (c_arvalid),
        .c_arready (c_arready),
        .c_rdata   (c_rdata),
        .c_rresp   (c_rresp),
        .c_rlast   (c_rlast),
        .c_rvalid  (c_rvalid),
        .c_rready  (c_rready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slaves();
        c_arready = 1'b0; c_rvalid = 1'b0; c_rdata = 32'h0; c_rresp = 2'b00; c_rlast = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00; s_rlast = 1'b0;
    endtask

    // One full read with the selected slave raising arready after ar_wait cycles of
    // arvalid and returning data the cycle after the AR handshake. The other slave
    // drives a bogus response during DATA which must not leak through.
    task automatic do_read(input logic [31:0] addr, input logic to_clint, input int ar_wait,
                           input logic [31:0] data, input logic [1:0] resp);
        idle_slaves();
        m_rready  = 1'b1;
        m_araddr  = addr;
        m_arvalid = 1'b1;
        #1;
        check("idle_arready", {31'h0, m_arready}, 32'h1);
        check("idle_rvalid", {31'h0, m_rvalid}, 32'h0);
        tick();
        m_arvalid = 1'b0;
        m_araddr  = ~addr;
        for (int i = 0; i <= ar_wait; i++) begin
            if (i == ar_wait) begin
                if (to_clint) c_arready = 1'b1;
                else          s_arready = 1'b1;
            end
            #1;
            check("addr_c_arvalid", {31'h0, c_arvalid}, {31'h0, to_clint});
            check("addr_s_arvalid", {31'h0, s_arvalid}, {31'h0, !to_clint});
            check("addr_c_araddr", c_araddr, addr);
            check("addr_s_araddr", s_araddr, addr);
            check("addr_arready", {31'h0, m_arready}, 32'h0);
            check("addr_rvalid", {31'h0, m_rvalid}, 32'h0);
            tick();
        end
        c_arready = 1'b0;
        s_arready = 1'b0;
        if (to_clint) begin
            c_rvalid = 1'b1; c_rdata = data; c_rresp = resp; c_rlast = 1'b1;
            s_rvalid = 1'b1; s_rdata = 32'hBAD0_0001; s_rresp = 2'b11; s_rlast = 1'b0;
        end else begin
            s_rvalid = 1'b1; s_rdata = data; s_rresp = resp; s_rlast = 1'b1;
            c_rvalid = 1'b1; c_rdata = 32'hBAD0_0002; c_rresp = 2'b11; c_rlast = 1'b0;
        end
        #1;
        check("data_rvalid", {31'h0, m_rvalid}, 32'h1);
        check("data_rdata", m_rdata, data);
        check("data_rresp", {30'h0, m_rresp}, {30'h0, resp});
        check("data_rlast", {31'h0, m_rlast}, 32'h1);
        check("data_c_rready", {31'h0, c_rready}, {31'h0, to_clint});
        check("data_s_rready", {31'h0, s_rready}, {31'h0, !to_clint});
        check("data_arvalids", {30'h0, c_arvalid, s_arvalid}, 32'h0);
        check("data_arready", {31'h0, m_arready}, 32'h0);
        tick();
        #1;
        check("done_rvalid", {31'h0, m_rvalid}, 32'h0);
        check("done_rdata", m_rdata, 32'h0);
        check("done_arready", {31'h0, m_arready}, 32'h1);
        check("done_rreadys", {30'h0, c_rready, s_rready}, 32'h0);
        idle_slaves();
    endtask

    initial begin
        reset     = 1'b0;
        m_araddr  = 32'h0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        idle_slaves();
        #2;
        check("rst_arready", {31'h0, m_arready}, 32'h1);
        check("rst_rvalid", {31'h0, m_rvalid}, 32'h0);
        check("rst_arvalids", {30'h0, c_arvalid, s_arvalid}, 32'h0);
        check("rst_rreadys", {30'h0, c_rready, s_rready}, 32'h0);
        check("rst_addr", c_araddr, 32'h0);
        #10;
        reset = 1'b1;
        tick();

        // CLINT read with zero-wait slave: accept N, arvalid N+1, rvalid N+2.
        do_read(32'h0200_0000, 1'b1, 0, 32'h0000_1234, 2'b00);

        // Memory read with arready delayed three cycles.
        do_read(32'h8000_0010, 1'b0, 3, 32'h5A5A_0010, 2'b00);

        // Decode boundaries.
        do_read(32'h0200_FFFC, 1'b1, 0, 32'h0000_FFFC, 2'b00);
        do_read(32'h0201_0000, 1'b0, 0, 32'h1111_0000, 2'b00);
        do_read(32'h01FF_FFFC, 1'b0, 0, 32'h2222_FFFC, 2'b00);

        // Back-pressure: m_rready low for five cycles in DATA.
        m_araddr  = 32'h8000_0100;
        m_arvalid = 1'b1;
        s_arready = 1'b1;
        tick();
        m_arvalid = 1'b0;
        tick();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 32'hCAFE_F00D;
        s_rlast   = 1'b1;
        m_rready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rvalid", {31'h0, m_rvalid}, 32'h1);
            check("bp_rdata", m_rdata, 32'hCAFE_F00D);
            check("bp_arready", {31'h0, m_arready}, 32'h0);
            check("bp_s_rready", {31'h0, s_rready}, 32'h0);
            tick();
        end
        m_rready = 1'b1;
        #1;
        check("bp_release_s_rready", {31'h0, s_rready}, 32'h1);
        check("bp_release_rvalid", {31'h0, m_rvalid}, 32'h1);
        tick();
        check("bp_done_arready", {31'h0, m_arready}, 32'h1);
        check("bp_done_rvalid", {31'h0, m_rvalid}, 32'h0);
        idle_slaves();

        // Reset while in ADDR abandons the transaction.
        m_araddr  = 32'h8000_0200;
        m_arvalid = 1'b1;
        tick();
        m_arvalid = 1'b0;
        check("abort_pre_s_arvalid", {31'h0, s_arvalid}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("abort_s_arvalid", {31'h0, s_arvalid}, 32'h0);
        check("abort_arready", {31'h0, m_arready}, 32'h1);
        check("abort_rreadys", {30'h0, c_rready, s_rready}, 32'h0);
        check("abort_addr", s_araddr, 32'h0);
        s_arready = 1'b1;
        s_rvalid  = 1'b1;
        s_rdata   = 32'hDEAD_0200;
        tick();
        reset = 1'b1;
        #1;
        check("abort_rel_rvalid", {31'h0, m_rvalid}, 32'h0);
        check("abort_rel_arvalid", {30'h0, c_arvalid, s_arvalid}, 32'h0);
        tick();
        check("abort_late_rvalid", {31'h0, m_rvalid}, 32'h0);
        check("abort_late_rdata", m_rdata, 32'h0);
        check("abort_late_s_rready", {31'h0, s_rready}, 32'h0);
        idle_slaves();
        do_read(32'h0200_0004, 1'b1, 0, 32'h0000_0004, 2'b00);

        // Slave error response passed through unmodified.
        do_read(32'h8000_0020, 1'b0, 1, 32'h0BAD_0020, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
